// File: rtl/mips_stage_skid_buffer.sv
// mips_stage_skid_buffer: two-entry valid/ready skid buffer with flush between pipeline stages
module mips_stage_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
);
  logic [1:0]       cnt, cnt_n;
  logic [WIDTH-1:0] main_q, main_n, skid_q, skid_n;
  logic             acc, con;
  assign in_ready  = cnt != 2'd2;
  assign out_valid = cnt != 2'd0;
  assign out_data  = main_q;
  assign count     = cnt;
  assign acc       = in_valid & in_ready;
  assign con       = out_valid & out_ready;
  // main reloads from skid when FULL drains, else from input when it is (or becomes) the head
  always_comb begin
    cnt_n  = flush ? 2'd0 : cnt + {1'b0, acc} - {1'b0, con};
    main_n = flush ? main_q
           : (cnt == 2'd2 && con) ? skid_q
           : (acc && (cnt == 2'd0 || con)) ? in_data : main_q;
    skid_n = (!flush && acc && cnt == 2'd1 && !con) ? in_data : skid_q;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt    <= 2'd0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      cnt    <= cnt_n;
      main_q <= main_n;
      skid_q <= skid_n;
    end
  end
endmodule
